// File: rtl/led_sw_pkg.sv
// led_sw_pkg: register map constants, bus width and address decode for led_sw_ctrl
package led_sw_pkg;
   localparam int DATA_W = 32;
   typedef enum logic [2:0] {
      A_SW    = 3'd0,
      A_LED   = 3'd1,
      A_EDGE  = 3'd2,
      A_MASK  = 3'd3,
      A_BLINK = 3'd4
   } addr_e;
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-FF synchronizer, tick-sampled history and debounced switch vector
module sw_debounce #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tick,
   input  logic [W-1:0] sw,
   output logic [W-1:0] deb,
   output logic [W-1:0] chg
);
   logic [W-1:0] s1, s2, samp, deb_q;
   // synchronize, then on each tick accept a bit only when two samples agree
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s1    <= '0;
         s2    <= '0;
         samp  <= '0;
         deb   <= '0;
         deb_q <= '0;
      end else begin
         s1    <= sw;
         s2    <= s1;
         deb_q <= deb;
         if (tick) begin
            samp <= s2;
            deb  <= (s2 & samp) | ((s2 ^ samp) & deb);
         end
      end
   assign chg = deb ^ deb_q;
endmodule

// File: rtl/led_sw_ctrl.sv
// led_sw_ctrl: Avalon-MM switch/LED peripheral with edge IRQ; optional blink via LED_SW_CTRL_BLINK_EN
module led_sw_ctrl
   import led_sw_pkg::*;
#(
   parameter int N_IO      = 10,
   parameter int DEB_TICK  = 50000,
   parameter int BLINK_DIV = 12500000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [DATA_W-1:0] avs_writedata,
   output logic [DATA_W-1:0] avs_readdata,
   input  logic [N_IO-1:0]   sw,
   output logic [N_IO-1:0]   ledr,
   output logic              irq
);
   localparam int DW = $clog2(DEB_TICK);
   localparam logic [DW-1:0] DMAX = DW'(DEB_TICK - 1);
   logic [DW-1:0]     dcnt;
   logic              tick;
   logic [N_IO-1:0]   deb, chg, led, edg, mask, blink, wd;
   logic [DATA_W-1:0] rd;
   addr_e             a;
   logic              unused_wd;
   assign a         = addr_e'(avs_address);
   assign wd        = avs_writedata[N_IO-1:0];
   assign tick      = dcnt == DMAX;
   assign unused_wd = ^avs_writedata;
   // free-running debounce prescaler
   always_ff @(posedge clk or posedge reset)
      if (reset) dcnt <= '0;
      else dcnt <= tick ? '0 : dcnt + 1'b1;
   sw_debounce #(.W(N_IO)) u_deb (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .sw   (sw),
      .deb  (deb),
      .chg  (chg)
   );
   // register file; a new edge overrides a same-cycle clearing write
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         led          <= '0;
         edg          <= '0;
         mask         <= '0;
         irq          <= 1'b0;
         avs_readdata <= '0;
      end else begin
         led  <= (avs_write && a == A_LED) ? wd : led;
         mask <= (avs_write && a == A_MASK) ? wd : mask;
         edg  <= chg | (edg & ~((avs_write && a == A_EDGE) ? wd : '0));
         irq  <= |(edg & mask);
         if (avs_read) avs_readdata <= rd;
      end
   // read mux, zero-extended to the bus width
   always_comb begin
      rd = '0;
      case (a)
         A_SW:    rd[N_IO-1:0] = deb;
         A_LED:   rd[N_IO-1:0] = led;
         A_EDGE:  rd[N_IO-1:0] = edg;
         A_MASK:  rd[N_IO-1:0] = mask;
         A_BLINK: rd[N_IO-1:0] = blink;
         default: rd = '0;
      endcase
   end
`ifdef LED_SW_CTRL_BLINK_EN
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);
   logic [BW-1:0] bcnt;
   logic          phase;
   // blink phase generator and BLINK register
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         bcnt  <= '0;
         phase <= 1'b0;
         blink <= '0;
      end else begin
         bcnt  <= bcnt == BMAX ? '0 : bcnt + 1'b1;
         phase <= bcnt == BMAX ? ~phase : phase;
         blink <= (avs_write && a == A_BLINK) ? wd : blink;
      end
   assign ledr = led & ~(blink & {N_IO{~phase}});
`else
   logic unused_blink;
   assign unused_blink = ^BLINK_DIV;
   assign blink        = '0;
   assign ledr         = led;
`endif
endmodule

// File: doc/led_sw_ctrl.md
LED_SW_CTRL -- requirements
Module: led_sw_ctrl

Interface
REQ-001 The block SHALL have parameter N_IO, default 10, giving the number of switches and LEDs (1..32).
REQ-002 The block SHALL have parameter DEB_TICK, default 50000, giving debounce sample period in clk cycles (1 ms at 50 MHz; >=2).
REQ-003 The block SHALL have parameter BLINK_DIV, default 12500000, giving blink half-period in clk cycles (>=2).
REQ-004 Port: clk  in  1  system clock, single clock domain.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: avs_address  in  3  word address.
REQ-007 Port: avs_read / avs_write  in  1 each  Avalon-MM strobes.
REQ-008 Port: avs_writedata  in  32 / avs_readdata  out  32.
REQ-009 Port: sw  in  N_IO  raw asynchronous switch inputs.
REQ-010 Port: ledr  out  N_IO  LED drive.
REQ-011 Port: irq  out  1  level interrupt to CPU.

Function
REQ-012 Avalon slave: no waitrequest; fixed read latency 1 (avs_readdata registered, valid the cycle after avs_read).
REQ-013 Register map: 0 SW (RO, debounced switches); 1 LED (RW); 2 EDGE (RW1C); 3 IRQ_MASK (RW); 4 BLINK (RW, see Configuration); 5-7 read 0, writes ignored.
REQ-014 Unused upper bits (>= N_IO) SHALL read 0 and ignore writes.
REQ-015 sw SHALL pass a 2-FF synchronizer before any use.
REQ-016 A free-running prescaler counting 0..DEB_TICK-1 SHALL emit a one-cycle tick at wrap.
REQ-017 On tick, each synchronized bit SHALL be sampled; debounced bit updates to the sample only when it equals the previous tick's sample (two consecutive agreeing samples).
REQ-018 A debounced bit change (either direction) SHALL set the matching EDGE bit the cycle after the change.
REQ-019 Writing 1 to an EDGE bit clears it; writing 0 leaves it; a new edge in the same cycle as a clearing write SHALL win (bit stays 1).
REQ-020 irq = |(EDGE & IRQ_MASK), registered, asserting one cycle after EDGE/mask update.
REQ-021 LED register write takes effect on ledr one cycle after avs_write.
REQ-022 Simultaneous avs_read and avs_write SHALL perform both; read returns pre-write value.

Reset
REQ-023 On reset: SW, LED, EDGE, IRQ_MASK, BLINK, debounce history, synchronizers, prescalers = 0; ledr = 0; irq = 0; avs_readdata = 0.
REQ-024 Reset asserted mid-debounce or mid-blink SHALL abandon it; no EDGE bit is set by the first post-reset debounced value (history starts at 0).

Configuration
REQ-025 Macro LED_SW_CTRL_BLINK_EN defined: BLINK register present; blink counter toggles a phase bit every BLINK_DIV cycles; ledr = LED & ~(BLINK & {N_IO{~phase}}).
REQ-026 Macro undefined: no blink counter or BLINK register; address 4 reads 0, writes ignored; ledr = LED.

Structure
REQ-027 Package led_sw_pkg SHALL hold register address constants, data width (32) and the address-decode enum.
REQ-028 Sub-module sw_debounce (synchronizer + per-bit history + debounced output) SHALL be instantiated once, vector width N_IO; prescaler lives in the top.

Verification (DEB_TICK=4, BLINK_DIV=8, N_IO=10)
REQ-029 Reset released, read addr 0 -> readdata 0x000 one cycle later; ledr=0, irq=0.
REQ-030 Write 0x2A5 to addr 1 -> ledr=0x2A5 next cycle; read addr 1 -> 0x2A5.
REQ-031 sw[3] 0->1 held stable -> SW reads 0x008 within 2+2*4 cycles; EDGE reads 0x008; with IRQ_MASK=0x008 irq=1; write 0x008 to addr 2 -> EDGE 0, irq 0.
REQ-032 sw[0] glitch high for 3 cycles -> SW stays 0, EDGE stays 0.
REQ-033 Clearing write to EDGE coincident with new edge on same bit -> bit reads 1 afterwards.
REQ-034 BLINK_EN: LED=0x3FF, BLINK=0x001 -> ledr[0] toggles every 8 cycles, ledr[9:1]=all 1; without macro, addr 4 reads 0.
